// File: rtl/remote_cmd_link.sv
// Host-side UART link: sends a 16-bit command as two 8N1 bytes (high byte first) and receives 8N1 response bytes.
// Latency: cmd_snt pulses 20*BAUD_DIV+1 clocks after an accepted snd_cmd; resp_rdy pulses at the receive stop-bit mid-point.
// Backpressure: snd_cmd is ignored while a command is in flight (including the DONE cycle); received bytes are never stalled.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   cmd, snd_cmd    command word and one-cycle send request
//   cmd_snt         one-cycle pulse after the second stop bit
//   TX              serial out, idles high
//   RX              asynchronous serial in
//   resp, resp_rdy  last correctly framed byte and its one-cycle strobe
module remote_cmd_link #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        TX,
    input  logic        RX,
    output logic [7:0]  resp,
    output logic        resp_rdy
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);

    // ---------------- transmit ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_SEND_HI, TX_SEND_LO, TX_DONE} tx_state_t;

    tx_state_t       tx_state_q;
    logic [15:0]     hold_q;
    logic [3:0]      tx_bit_q;
    logic [BW-1:0]   tx_baud_q;
    logic            tx_q;
    logic            cmd_snt_q;
    logic [7:0]      tx_byte;
    logic            tx_next_d;

    // Level of the bit that follows the current one within the frame:
    // index 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
    always_comb begin
        tx_byte   = (tx_state_q == TX_SEND_HI) ? hold_q[15:8] : hold_q[7:0];
        tx_next_d = (tx_bit_q == 4'd8) ? 1'b1 : tx_byte[tx_bit_q[2:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            hold_q     <= '0;
            tx_bit_q   <= '0;
            tx_baud_q  <= '0;
            tx_q       <= 1'b1;
            cmd_snt_q  <= 1'b0;
        end else begin
            cmd_snt_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (snd_cmd) begin
                        hold_q     <= cmd;
                        tx_q       <= 1'b0;
                        tx_bit_q   <= '0;
                        tx_baud_q  <= '0;
                        tx_state_q <= TX_SEND_HI;
                    end
                end
                TX_SEND_HI, TX_SEND_LO: begin
                    if (tx_baud_q == BAUD_LAST) begin
                        tx_baud_q <= '0;
                        if (tx_bit_q == 4'd9) begin
                            tx_bit_q <= '0;
                            if (tx_state_q == TX_SEND_HI) begin
                                // Low byte start bit follows the high stop bit directly.
                                tx_q       <= 1'b0;
                                tx_state_q <= TX_SEND_LO;
                            end else begin
                                tx_q       <= 1'b1;
                                cmd_snt_q  <= 1'b1;
                                tx_state_q <= TX_DONE;
                            end
                        end else begin
                            tx_bit_q <= tx_bit_q + 4'd1;
                            tx_q     <= tx_next_d;
                        end
                    end else begin
                        tx_baud_q <= tx_baud_q + 1'b1;
                    end
                end
                TX_DONE:  tx_state_q <= TX_IDLE;
                default:  tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign TX      = tx_q;
    assign cmd_snt = cmd_snt_q;

    // ---------------- receive ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t       rx_state_q;
    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    logic [3:0]      rx_bit_q;
    logic [BW-1:0]   rx_baud_q;
    logic [7:0]      rx_shift_q;
    logic [7:0]      resp_q;
    logic            resp_rdy_q;
    logic            rx_fall;

    // A falling edge needs a high level first, so after a framing error the
    // FSM only rearms once the line has returned high.
    assign rx_fall = rx_prev_q & ~rx_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_bit_q   <= '0;
            rx_baud_q  <= '0;
            rx_shift_q <= '0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
        end else begin
            rx_s1_q    <= RX;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            resp_rdy_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_baud_q  <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_baud_q == BAUD_HALF) begin
                        rx_baud_q <= '0;
                        rx_bit_q  <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_baud_q <= rx_baud_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_baud_q == BAUD_LAST) begin
                        rx_baud_q  <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 4'd1;
                        if (rx_bit_q == 4'd7) rx_state_q <= RX_STOP;
                    end else begin
                        rx_baud_q <= rx_baud_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_baud_q == BAUD_LAST) begin
                        rx_baud_q  <= '0;
                        rx_state_q <= RX_IDLE;
                        if (rx_s2_q) begin
                            resp_q     <= rx_shift_q;
                            resp_rdy_q <= 1'b1;
                        end
                    end else begin
                        rx_baud_q <= rx_baud_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign resp     = resp_q;
    assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_cmd_link.sv
module tb_remote_cmd_link;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        TX;
    logic        RX;
    logic [7:0]  resp;
    logic        resp_rdy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         tx_starts[$];
    bit         tx_mon_en = 1'b1;
    int         snt_cnt = 0, snt_cyc = 0;
    int         rdy_cnt = 0, rdy_cyc = 0;

    remote_cmd_link #(.BAUD_DIV(BD)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt),
        .TX(TX), .RX(RX), .resp(resp), .resp_rdy(resp_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_snd(input logic [15:0] c);
        cmd = c;
        snd_cmd = 1'b1;
        tick(1);
        snd_cmd = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        tick(BD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(BD);
        end
        RX = stop;
        tick(BD);
        RX = 1'b1;
    endtask

    // TX line decoder: samples each bit at its centre and checks against the scoreboard.
    initial begin
        logic [7:0]  d;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx_mon_en && TX === 1'b0) begin
                tx_starts.push_back(cyc);
                repeat (BD / 2) @(negedge clk);
                check("tx_start_bit", {31'd0, TX}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    d[i] = TX;
                end
                repeat (BD) @(negedge clk);
                check("tx_stop_bit", {31'd0, TX}, 32'd1);
                e = (tx_exp.size() > 0) ? {24'd0, tx_exp.pop_front()} : 32'hDEAD;
                check("tx_byte", {24'd0, d}, e);
            end
        end
    end

    always @(negedge clk) begin
        if (cmd_snt === 1'b1) begin
            snt_cnt++;
            snt_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (resp_rdy === 1'b1) begin
            rdy_cnt++;
            rdy_cyc = cyc;
            e = (rx_exp.size() > 0) ? {24'd0, rx_exp.pop_front()} : 32'hDEAD;
            check("rx_resp", {24'd0, resp}, e);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int snd_c, rx_c, n0, s0, s1;

        // 1. reset
        rst = 1'b1; cmd = '0; snd_cmd = 1'b0; RX = 1'b1;
        tick(2);
        rst = 1'b0;
        check("rst_tx", {31'd0, TX}, 32'd1);
        check("rst_cmd_snt", {31'd0, cmd_snt}, 32'd0);
        check("rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
        check("rst_resp", {24'd0, resp}, 32'd0);
        tick(3);

        // 2. send 0x4004, check framing, inter-frame gap and latency
        tx_starts.delete();
        tx_exp.push_back(8'h40);
        tx_exp.push_back(8'h04);
        snd_c = cyc;
        pulse_snd(16'h4004);
        tick(330);
        check("snt_count_1", snt_cnt, 1);
        check("snt_latency", snt_cyc - snd_c, 20 * BD + 1);
        check("tx_frames_seen", tx_starts.size(), 2);
        s0 = (tx_starts.size() > 0) ? tx_starts.pop_front() : -1;
        s1 = (tx_starts.size() > 0) ? tx_starts.pop_front() : -1;
        check("tx_first_start", s0 - snd_c, 1);
        check("tx_no_gap", s1 - s0, 10 * BD);
        check("tx_queue_empty_1", tx_exp.size(), 0);

        // 3. busy reject
        tx_exp.push_back(8'h40);
        tx_exp.push_back(8'h04);
        pulse_snd(16'h4004);
        tick(100);
        pulse_snd(16'h2001);
        tick(240);
        check("snt_count_busy", snt_cnt, 2);
        check("tx_queue_empty_2", tx_exp.size(), 0);
        tick(20);
        check("tx_idle_after_busy", {31'd0, TX}, 32'd1);

        // 4. receive 0xA5 then 0x5A back-to-back
        rx_exp.push_back(8'hA5);
        rx_exp.push_back(8'h5A);
        rx_c = cyc;
        rx_byte(8'hA5, 1'b1);
        check("rx_first_pulse_cnt", rdy_cnt, 1);
        check("rx_pulse_window", ((rdy_cyc - rx_c) >= 148 && (rdy_cyc - rx_c) <= 160) ? 32'd1 : 32'd0, 32'd1);
        rx_byte(8'h5A, 1'b1);
        tick(2 * BD);
        check("rx_pulse_cnt_2", rdy_cnt, 2);
        check("rx_resp_hold", {24'd0, resp}, 32'h5A);
        check("rx_queue_empty", rx_exp.size(), 0);

        // 5. glitch and framing error
        n0 = rdy_cnt;
        RX = 1'b0;
        tick(4);
        RX = 1'b1;
        tick(3 * BD);
        check("rx_glitch_no_rdy", rdy_cnt, n0);
        rx_byte(8'h33, 1'b0);
        tick(3 * BD);
        check("rx_frame_err_no_rdy", rdy_cnt, n0);
        check("rx_frame_err_resp", {24'd0, resp}, 32'h5A);
        rx_exp.push_back(8'hC3);
        rx_byte(8'hC3, 1'b1);
        tick(2 * BD);
        check("rx_rearm_after_err", rdy_cnt, n0 + 1);

        // 6. reset during SEND_LO data bits, then a normal send
        tx_mon_en = 1'b0;
        n0 = snt_cnt;
        pulse_snd(16'hFF00);
        tick(199);
        check("tx_lo_data_low", {31'd0, TX}, 32'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("tx_high_after_rst", {31'd0, TX}, 32'd1);
        check("resp_cleared_by_rst", {24'd0, resp}, 32'd0);
        tick(400);
        check("no_snt_after_abort", snt_cnt, n0);
        check("tx_idle_after_abort", {31'd0, TX}, 32'd1);
        tx_mon_en = 1'b1;
        tx_starts.delete();
        tx_exp.push_back(8'h12);
        tx_exp.push_back(8'h34);
        snd_c = cyc;
        pulse_snd(16'h1234);
        tick(330);
        check("snt_after_recover", snt_cnt, n0 + 1);
        check("snt_latency_2", snt_cyc - snd_c, 20 * BD + 1);
        check("tx_queue_empty_3", tx_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
